// File: rtl/periph_xfer_scheduler_if.sv
// Processor-side queue port and the two peripheral send/ack handshakes of periph_xfer_scheduler.
// The scheduler uses the slave modport; the processor/peripheral side uses master.
interface periph_xfer_scheduler_if #(
    parameter int DW    = 16,
    parameter int DEPTH = 4
);
    logic                   in_valid;
    logic [DW-1:0]          in_data;
    logic                   in_ready;
    logic [DW-1:0]          dado1;
    logic                   send1;
    logic                   ack1;
    logic [DW-1:0]          dado2;
    logic                   send2;
    logic                   ack2;
    logic [$clog2(DEPTH):0] level;
    logic                   busy;
    logic [1:0]             err;

    modport slave (
        input  in_valid, in_data, ack1, ack2,
        output in_ready, dado1, send1, dado2, send2, level, busy, err
    );

    modport master (
        output in_valid, in_data, ack1, ack2,
        input  in_ready, dado1, send1, dado2, send2, level, busy, err
    );
endinterface

// File: rtl/periph_xfer_scheduler.sv
// Word FIFO feeding two peripherals over 4-phase send/ack handshakes, round-robin
// dispatch of the queue head to an idle channel, per-channel ack timeout with sticky error.
module periph_xfer_scheduler #(
    parameter int DW      = 16,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input logic                    clk,
    input logic                    rst,
    periph_xfer_scheduler_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        REL
    } ch_state_t;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [LW-1:0] count;
    logic          rdy;
    logic          push;
    logic          pop;

    ch_state_t     st    [2];
    ch_state_t     st_n  [2];
    logic [CW-1:0] cnt   [2];
    logic [CW-1:0] cnt_n [2];
    logic [DW-1:0] dado  [2];
    logic [1:0]    ack;
    logic [1:0]    grant;
    logic [1:0]    abort;
    logic [1:0]    err_q;
    logic          rr;      // channel granted last: 0 = periph1, 1 = periph2

    assign ack  = {bus.ack2, bus.ack1};
    assign rdy  = (count != LW'(DEPTH));
    assign push = bus.in_valid && rdy;
    assign pop  = |grant;

    always_comb begin
        grant = '0;
        abort = '0;
        if (count != '0) begin
            if (st[0] == IDLE && st[1] == IDLE) grant = rr ? 2'b01 : 2'b10;
            else if (st[0] == IDLE)             grant = 2'b01;
            else if (st[1] == IDLE)             grant = 2'b10;
        end
        for (int unsigned i = 0; i < 2; i++) begin
            st_n[i]  = st[i];
            cnt_n[i] = cnt[i];
            unique case (st[i])
                IDLE: begin
                    if (grant[i]) begin
                        st_n[i]  = REQ;
                        cnt_n[i] = '0;
                    end
                end
                REQ: begin
                    // cnt counts completed REQ cycles, so send stays high exactly TIMEOUT cycles
                    if (ack[i]) begin
                        st_n[i] = REL;
                    end else if (cnt[i] == CW'(TIMEOUT - 1)) begin
                        st_n[i]  = IDLE;
                        abort[i] = 1'b1;
                    end else begin
                        cnt_n[i] = cnt[i] + 1'b1;
                    end
                end
                REL: begin
                    if (!ack[i]) st_n[i] = IDLE;
                end
                default: st_n[i] = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            rr    <= 1'b1;
            err_q <= '0;
            for (int unsigned i = 0; i < 2; i++) begin
                st[i]   <= IDLE;
                cnt[i]  <= '0;
                dado[i] <= '0;
            end
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            if (push && !pop)      count <= count + 1'b1;
            else if (!push && pop) count <= count - 1'b1;
            if (pop) rr <= grant[1];
            err_q <= err_q | abort;
            for (int unsigned i = 0; i < 2; i++) begin
                st[i]  <= st_n[i];
                cnt[i] <= cnt_n[i];
                if (grant[i]) dado[i] <= mem[rptr];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= bus.in_data;
    end

    assign bus.in_ready = rdy;
    assign bus.level    = count;
    assign bus.send1    = (st[0] == REQ);
    assign bus.send2    = (st[1] == REQ);
    assign bus.dado1    = dado[0];
    assign bus.dado2    = dado[1];
    assign bus.err      = err_q;
    assign bus.busy     = (count != '0) || (st[0] != IDLE) || (st[1] != IDLE);
endmodule
